// File: rtl/dds_tone_source.sv
// rtl/dds_tone_source.sv - quarter-wave DDS tone source with soft gain ramp and full backpressure stall
module dds_tone_source #(
    parameter int PHASE_W  = 32,
    parameter int LUT_AW   = 8,
    parameter int SAMPLE_W = 24,
    parameter int GAIN_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PHASE_W-1:0]         phase_inc,
    input  logic [GAIN_W-1:0]          gain,
    input  logic                       mute,
    input  logic                       audio_full,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    output logic [GAIN_W-1:0]          gain_eff
);

    localparam int PROD_W   = SAMPLE_W + GAIN_W + 1;
    localparam int FRAC     = 48;
    localparam int LUT_SIZE = 2 ** LUT_AW;

    typedef logic signed [127:0] wide_t;

    // pi/2 in 2^-48 fixed point
    localparam wide_t PI_HALF_FX = 128'sd442139859501778;

    // Table entry i = round(amp * sin(pi/2 * (i + 0.5) / 2^LUT_AW)), evaluated at
    // elaboration by a fixed-point Taylor series so the table tracks the parameters.
    function automatic logic [SAMPLE_W-1:0] rom_entry(input int idx);
        wide_t x;
        wide_t x2;
        wide_t term;
        wide_t acc;
        wide_t amp;
        x    = (PI_HALF_FX * wide_t'(2 * idx + 1)) >>> (LUT_AW + 1);
        x2   = (x * x) >>> FRAC;
        term = x;
        acc  = '0;
        for (int k = 1; k <= 10; k++) begin
            acc  = acc + term;
            term = -(((term * x2) >>> FRAC) / wide_t'(2 * k * (2 * k + 1)));
        end
        amp = wide_t'((1 << (SAMPLE_W - 1)) - 1);
        return SAMPLE_W'((amp * acc + (wide_t'(1) <<< (FRAC - 1))) >>> FRAC);
    endfunction

    logic [SAMPLE_W-1:0] rom_tbl [LUT_SIZE];

    for (genvar i = 0; i < LUT_SIZE; i++) begin : g_rom
        localparam logic [SAMPLE_W-1:0] ROM_VAL = rom_entry(i);
        assign rom_tbl[i] = ROM_VAL;
    end

    logic                       adv;
    logic [PHASE_W-1:0]         phase_acc;
    logic [1:0]                 quad;
    logic [LUT_AW-1:0]          frac_addr;
    logic [LUT_AW-1:0]          addr1;
    logic                       neg1;
    logic                       neg2;
    logic [SAMPLE_W-1:0]        rom2;
    logic signed [SAMPLE_W-1:0] s3;
    logic                       v1;
    logic                       v2;
    logic                       v3;
    logic signed [PROD_W-1:0]   product;
    logic [GAIN_W-1:0]          target;

    assign adv       = !audio_full;
    assign quad      = phase_acc[PHASE_W-1 -: 2];
    assign frac_addr = phase_acc[PHASE_W-3 -: LUT_AW];
    assign target    = mute ? '0 : gain;
    assign product   = PROD_W'(s3) * PROD_W'($signed({1'b0, gain_eff}));

    // Stage valid bits keep the table read of the reset address from leaking out
    // before the first real phase reaches the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_acc    <= '0;
            addr1        <= '0;
            neg1         <= 1'b0;
            neg2         <= 1'b0;
            rom2         <= '0;
            s3           <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            v3           <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            gain_eff     <= '0;
        end else if (adv) begin
            phase_acc <= phase_acc + phase_inc;
            addr1     <= quad[0] ? ~frac_addr : frac_addr;
            neg1      <= quad[1];
            v1        <= 1'b1;

            rom2 <= v1 ? rom_tbl[addr1] : '0;
            neg2 <= neg1;
            v2   <= v1;

            s3 <= neg2 ? -rom2 : rom2;
            v3 <= v2;

            sample_out <= SAMPLE_W'(product >>> GAIN_W);
            if (v3) begin
                sample_valid <= 1'b1;
            end

            if (gain_eff < target) begin
                gain_eff <= gain_eff + GAIN_W'(1);
            end else if (gain_eff > target) begin
                gain_eff <= gain_eff - GAIN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dds_tone_source.sv
// tb/tb_dds_tone_source.sv - randomized scoreboard bench for dds_tone_source against a sine reference model
module tb_dds_tone_source;

    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = 8388607.0;

    logic               clk = 1'b0;
    logic               reset;
    logic [31:0]        phase_inc;
    logic [7:0]         gain;
    logic               mute;
    logic               audio_full;
    logic signed [23:0] sample_out;
    logic               sample_valid;
    logic [7:0]         gain_eff;

    always #5 clk = ~clk;

    dds_tone_source dut (
        .clk          (clk),
        .reset        (reset),
        .phase_inc    (phase_inc),
        .gain         (gain),
        .mute         (mute),
        .audio_full   (audio_full),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .gain_eff     (gain_eff)
    );

    typedef struct {
        logic signed [23:0] s;
        logic               v;
        logic [7:0]         g;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_out;
    logic [31:0] m_phase;
    logic [31:0] m_hist[$];
    int          m_gain;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Output waveform: one of 1024 bins per cycle, value taken at the bin centre.
    function automatic int wave(input logic [31:0] p);
        real v;
        int  k;
        k = int'(p >> 22);
        v = AMP * $sin(2.0 * PI * (real'(k) + 0.5) / 1024.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    task automatic model_edge(input logic rst, input logic full);
        longint prod;
        int     target;
        if (rst) begin
            m_phase = '0;
            m_gain  = 0;
            m_hist.delete();
            m_out   = '{s: '0, v: 1'b0, g: '0};
        end else if (!full) begin
            m_hist.push_back(m_phase);
            m_phase = m_phase + phase_inc;
            if (m_hist.size() == 4) begin
                prod    = longint'(wave(m_hist.pop_front())) * m_gain;
                m_out.s = 24'(prod >>> 8);
                m_out.v = 1'b1;
            end else begin
                m_out.s = '0;
            end
            target = mute ? 0 : int'(gain);
            if (m_gain < target) m_gain++;
            else if (m_gain > target) m_gain--;
            m_out.g = 8'(m_gain);
        end
        sb_q.push_back(m_out);
    endtask

    task automatic tick(input logic rst, input logic full);
        reset      = rst;
        audio_full = full;
        @(posedge clk);
        model_edge(rst, full);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("no_x", longint'($isunknown({sample_out, sample_valid, gain_eff})), 0);
            check("sample_out", sample_out, e.s);
            check("sample_valid", sample_valid, e.v);
            check("gain_eff", gain_eff, e.g);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int                 n;
        int                 pat[4];
        logic signed [23:0] held;
        pat = '{25635, 8355800, -25636, -8355801};

        reset      = 1'b1;
        audio_full = 1'b0;
        mute       = 1'b0;
        gain       = 8'd0;
        phase_inc  = 32'h0123_4567;
        @(negedge clk);

        // reset, then first four advances with zero gain
        tick(1, 0);
        tick(1, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_sample", sample_out, 0);
        check("rst_gain", gain_eff, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0);
            check("early_valid", sample_valid, 0);
            check("early_sample", sample_out, 0);
        end
        tick(0, 0);
        check("fourth_valid", sample_valid, 1);
        check("fourth_sample", sample_out, 0);

        // quarter-rate tone at full gain, then a mid-run stall
        phase_inc = 32'h4000_0000;
        gain      = 8'd255;
        tick(1, 0);
        n = 0;
        repeat (300) begin
            tick(0, 0);
            n++;
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 0);
            n++;
            check("quad_pattern", sample_out, pat[(n - 4) % 4]);
        end
        held = sample_out;
        for (int i = 0; i < 10; i++) begin
            tick(0, 1);
            check("stall_sample", sample_out, held);
            check("stall_gain", gain_eff, 255);
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 0);
            n++;
            check("resume_pattern", sample_out, pat[(n - 4) % 4]);
        end

        // mute ramp down and back up
        mute = 1'b1;
        repeat (255) tick(0, 0);
        check("mute_gain", gain_eff, 0);
        tick(0, 0);
        check("mute_sample", sample_out, 0);
        mute = 1'b0;
        repeat (255) tick(0, 0);
        check("unmute_gain", gain_eff, 255);

        // backwards phase across the wrap
        phase_inc = 32'hFFFF_FFFF;
        tick(1, 0);
        repeat (40) tick(0, 0);
        check("wrap_no_x", longint'($isunknown(sample_out)), 0);

        // reset while stalled
        phase_inc = 32'h0765_4321;
        repeat (20) tick(0, 0);
        tick(1, 1);
        check("stall_rst_sample", sample_out, 0);
        check("stall_rst_valid", sample_valid, 0);
        check("stall_rst_gain", gain_eff, 0);
        check("stall_rst_phase", dut.phase_acc, 0);

        // sweep every bin at full gain
        phase_inc = 32'h0040_0000;
        gain      = 8'd255;
        repeat (1400) tick(0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0: phase_inc = $urandom;
                    1: phase_inc = 32'h0040_0000;
                    2: phase_inc = 32'($urandom_range(0, 1000));
                    default: phase_inc = 32'h0;
                endcase
                gain = 8'($urandom_range(0, 255));
                mute = ($urandom_range(0, 4) == 0);
            end
            tick(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25));
        end

        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
